// File: rtl/parking_gate_arbiter.sv
// rtl/parking_gate_arbiter.sv - two-lane parking gate arbiter with keypad check, lockout and occupancy count
module parking_gate_arbiter #(
   parameter int unsigned CAPACITY    = 9,
   parameter logic [1:0]  PASS_A      = 2'b10,
   parameter logic [1:0]  PASS_B      = 2'b01,
   parameter int unsigned OPEN_CYCLES = 8,
   parameter int unsigned MAX_TRIES   = 3,
   parameter int unsigned LOCK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_a,
   input  logic       req_b,
   input  logic [1:0] password,
   input  logic       pass_vld,
   input  logic       back_sensor,
   input  logic       exit_sensor,
   output logic       grant_a,
   output logic       grant_b,
   output logic       green_LED,
   output logic       red_LED,
   output logic [3:0] display_screen,
   output logic       full,
   output logic       lockout
);

   localparam int unsigned TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
   localparam int unsigned TW   = $clog2(TMAX + 1);
   localparam int unsigned CW   = (MAX_TRIES > 1) ? $clog2(MAX_TRIES + 1) : 1;

   localparam logic [3:0]    CAP       = 4'(CAPACITY);
   localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES);
   localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES);
   localparam logic [TW-1:0] TIMER_ONE = TW'(1);
   localparam logic [CW-1:0] TRY_LIMIT = CW'(MAX_TRIES);
   localparam logic [CW-1:0] TRY_ONE   = CW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      OPEN  = 2'd2,
      LOCK  = 2'd3
   } state_t;

   // lane encoding: 0 = lane A, 1 = lane B
   state_t        state, state_n;
   logic          lane, lane_n;
   logic          rr, rr_n;
   logic [TW-1:0] timer, timer_n;
   logic [CW-1:0] tries, tries_n;
   logic [3:0]    occ, occ_n;

   logic          entry;
   logic          leave;
   logic          lane_req;
   logic [1:0]    lane_code;

   logic          grant_a_n, grant_b_n, green_n, red_n, full_n, lockout_n;
   logic [3:0]    display_n;

   // next-state, occupancy and next-output decode
   always_comb begin
      state_n   = state;
      lane_n    = lane;
      rr_n      = rr;
      timer_n   = timer;
      tries_n   = tries;
      entry     = 1'b0;
      lane_req  = lane ? req_b : req_a;
      lane_code = lane ? PASS_B : PASS_A;

      case (state)
         IDLE: begin
            // grant decision uses the registered count, so an exit this cycle
            // only unblocks the gate on the following cycle
            if (occ != CAP && (req_a || req_b)) begin
               state_n = CHECK;
               tries_n = '0;
               lane_n  = (req_a && req_b) ? rr : req_b;
            end
         end
         CHECK: begin
            if (pass_vld) begin
               if (password == lane_code) begin
                  state_n = OPEN;
                  timer_n = OPEN_LOAD;
                  tries_n = '0;
               end else if (tries + TRY_ONE == TRY_LIMIT) begin
                  state_n = LOCK;
                  timer_n = LOCK_LOAD;
                  tries_n = '0;
               end else begin
                  tries_n = tries + TRY_ONE;
               end
            end else if (!lane_req) begin
               // abandon leaves the round-robin pointer where it was
               state_n = IDLE;
               tries_n = '0;
            end
         end
         OPEN: begin
            // a car passing on the last open cycle still counts
            if (back_sensor) begin
               entry   = 1'b1;
               state_n = IDLE;
               timer_n = '0;
               rr_n    = ~lane;
            end else if (timer <= TIMER_ONE) begin
               state_n = IDLE;
               timer_n = '0;
               rr_n    = ~lane;
            end else begin
               timer_n = timer - TIMER_ONE;
            end
         end
         LOCK: begin
            if (timer <= TIMER_ONE) begin
               state_n = IDLE;
               timer_n = '0;
               rr_n    = ~lane;
            end else begin
               timer_n = timer - TIMER_ONE;
            end
         end
         default: begin
            state_n = IDLE;
            timer_n = '0;
            tries_n = '0;
         end
      endcase

      leave = exit_sensor && (occ != 4'd0);
      occ_n = occ;
      if (entry && !leave) begin
         occ_n = occ + 4'd1;
      end else if (leave && !entry) begin
         occ_n = occ - 4'd1;
      end

      grant_a_n = (state_n == CHECK || state_n == OPEN) && !lane_n;
      grant_b_n = (state_n == CHECK || state_n == OPEN) && lane_n;
      green_n   = (state_n == OPEN);
      full_n    = (occ_n == CAP);
      lockout_n = (state_n == LOCK);
      red_n     = (state_n == CHECK) || (state_n == LOCK) || (state_n == IDLE && full_n);
      display_n = CAP - occ_n;
   end

   // state, counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         lane           <= 1'b0;
         rr             <= 1'b0;
         timer          <= '0;
         tries          <= '0;
         occ            <= 4'd0;
         grant_a        <= 1'b0;
         grant_b        <= 1'b0;
         green_LED      <= 1'b0;
         red_LED        <= 1'b0;
         full           <= 1'b0;
         lockout        <= 1'b0;
         display_screen <= CAP;
      end else begin
         state          <= state_n;
         lane           <= lane_n;
         rr             <= rr_n;
         timer          <= timer_n;
         tries          <= tries_n;
         occ            <= occ_n;
         grant_a        <= grant_a_n;
         grant_b        <= grant_b_n;
         green_LED      <= green_n;
         red_LED        <= red_n;
         full           <= full_n;
         lockout        <= lockout_n;
         display_screen <= display_n;
      end
   end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb/tb_parking_gate_arbiter.sv - directed vector bench for parking_gate_arbiter
module tb_parking_gate_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_a = 1'b0;
   logic       req_b = 1'b0;
   logic [1:0] password = 2'b00;
   logic       pass_vld = 1'b0;
   logic       back_sensor = 1'b0;
   logic       exit_sensor = 1'b0;
   logic       grant_a, grant_b, green_LED, red_LED, full, lockout;
   logic [3:0] display_screen;

   int checks = 0;
   int errors = 0;

   parking_gate_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .req_a          (req_a),
      .req_b          (req_b),
      .password       (password),
      .pass_vld       (pass_vld),
      .back_sensor    (back_sensor),
      .exit_sensor    (exit_sensor),
      .grant_a        (grant_a),
      .grant_b        (grant_b),
      .green_LED      (green_LED),
      .red_LED        (red_LED),
      .display_screen (display_screen),
      .full           (full),
      .lockout        (lockout)
   );

   always #5 clk = ~clk;

   // ctl = {grant_a, grant_b, green_LED, red_LED, lockout, full}
   typedef struct {
      logic       r;
      logic       ra;
      logic       rb;
      logic [1:0] pw;
      logic       pv;
      logic       bk;
      logic       ex;
      logic [5:0] ctl;
      logic [3:0] disp;
   } vec_t;

   localparam int NV = 37;
   vec_t vecs [NV];

   function automatic logic [9:0] outs();
      return {grant_a, grant_b, green_LED, red_LED, lockout, full, display_screen};
   endfunction

   task automatic step(input logic r, input logic ra, input logic rb, input logic [1:0] pw,
                       input logic pv, input logic bk, input logic ex);
      rst = r; req_a = ra; req_b = rb; password = pw;
      pass_vld = pv; back_sensor = bk; exit_sensor = ex;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [9:0] exp);
      logic [9:0] act;
      act = outs();
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got ga/gb/gr/rd/lk/fl=%b disp=%0d, required %b disp=%0d",
                  name, act[9:4], act[3:0], exp[9:4], exp[3:0]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      //             r  ra rb pw     pv bk ex  ctl        disp
      vecs[0]  = '{1, 0, 0, 2'b00, 0, 0, 0, 6'b000000, 4'd9}; // reset
      vecs[1]  = '{0, 0, 0, 2'b00, 0, 0, 1, 6'b000000, 4'd9}; // exit at 0
      vecs[2]  = '{0, 1, 0, 2'b00, 0, 0, 0, 6'b100100, 4'd9}; // grant A
      vecs[3]  = '{0, 1, 0, 2'b10, 1, 0, 0, 6'b101000, 4'd9}; // code ok
      vecs[4]  = '{0, 1, 0, 2'b00, 0, 0, 0, 6'b101000, 4'd9};
      vecs[5]  = '{0, 1, 0, 2'b00, 0, 0, 0, 6'b101000, 4'd9};
      vecs[6]  = '{0, 1, 0, 2'b00, 0, 1, 0, 6'b000000, 4'd8}; // entry
      vecs[7]  = '{0, 0, 0, 2'b00, 0, 0, 0, 6'b000000, 4'd8};
      vecs[8]  = '{1, 0, 0, 2'b00, 0, 0, 0, 6'b000000, 4'd9}; // reset
      vecs[9]  = '{0, 1, 1, 2'b00, 0, 0, 0, 6'b100100, 4'd9}; // contention -> A
      vecs[10] = '{0, 1, 1, 2'b10, 1, 0, 0, 6'b101000, 4'd9};
      vecs[11] = '{0, 1, 1, 2'b00, 0, 1, 0, 6'b000000, 4'd8};
      vecs[12] = '{0, 1, 1, 2'b00, 0, 0, 0, 6'b010100, 4'd8}; // then B
      vecs[13] = '{0, 1, 1, 2'b01, 1, 0, 0, 6'b011000, 4'd8};
      vecs[14] = '{0, 0, 0, 2'b00, 0, 1, 1, 6'b000000, 4'd8}; // entry + exit
      vecs[15] = '{0, 0, 0, 2'b00, 0, 0, 0, 6'b000000, 4'd8};
      vecs[16] = '{0, 1, 0, 2'b00, 0, 0, 0, 6'b100100, 4'd8};
      vecs[17] = '{0, 1, 0, 2'b10, 1, 0, 0, 6'b101000, 4'd8}; // open, timeout run
      for (int i = 18; i <= 24; i++)
         vecs[i] = '{0, 0, 0, 2'b00, 0, 0, 0, 6'b101000, 4'd8};
      vecs[25] = '{0, 0, 0, 2'b00, 0, 0, 0, 6'b000000, 4'd8}; // expired, no entry
      vecs[26] = '{0, 0, 1, 2'b00, 0, 0, 0, 6'b010100, 4'd8};
      vecs[27] = '{0, 0, 1, 2'b00, 1, 0, 0, 6'b010100, 4'd8}; // wrong code
      vecs[28] = '{0, 0, 0, 2'b00, 0, 0, 0, 6'b000000, 4'd8}; // abandon
      vecs[29] = '{0, 1, 1, 2'b00, 0, 0, 0, 6'b010100, 4'd8}; // rr still B
      vecs[30] = '{0, 1, 1, 2'b10, 1, 0, 0, 6'b010100, 4'd8}; // A code on B
      vecs[31] = '{0, 0, 0, 2'b01, 1, 0, 0, 6'b011000, 4'd8}; // pass beats drop
      vecs[32] = '{0, 0, 0, 2'b00, 0, 1, 0, 6'b000000, 4'd7};
      vecs[33] = '{0, 1, 0, 2'b00, 0, 0, 0, 6'b100100, 4'd7};
      vecs[34] = '{0, 1, 0, 2'b10, 1, 0, 0, 6'b101000, 4'd7};
      vecs[35] = '{1, 1, 0, 2'b00, 0, 1, 0, 6'b000000, 4'd9}; // reset mid-open
      vecs[36] = '{0, 0, 0, 2'b00, 0, 0, 0, 6'b000000, 4'd9};

      for (int i = 0; i < NV; i++) begin
         step(vecs[i].r, vecs[i].ra, vecs[i].rb, vecs[i].pw, vecs[i].pv, vecs[i].bk, vecs[i].ex);
         check($sformatf("vec%0d", i), {vecs[i].ctl, vecs[i].disp});
      end

      // lockout on lane B, then contested grant returns to lane A
      step(1, 0, 0, 2'b00, 0, 0, 0);
      step(0, 0, 1, 2'b00, 0, 0, 0);
      check("lock_grant_b", {6'b010100, 4'd9});
      step(0, 0, 1, 2'b00, 1, 0, 0);
      check("lock_try1", {6'b010100, 4'd9});
      step(0, 0, 1, 2'b00, 1, 0, 0);
      check("lock_try2", {6'b010100, 4'd9});
      step(0, 0, 1, 2'b00, 1, 0, 0);
      check("lock_enter", {6'b000110, 4'd9});
      for (int i = 1; i < 16; i++) begin
         step(0, 0, 0, 2'b01, i[0], 0, 0);
         check($sformatf("lock_hold%0d", i), {6'b000110, 4'd9});
      end
      step(0, 0, 0, 2'b00, 0, 0, 0);
      check("lock_release", {6'b000000, 4'd9});
      step(0, 1, 1, 2'b00, 0, 0, 0);
      check("lock_then_a", {6'b100100, 4'd9});

      // fill the lot, blocked request, exit releases it
      step(1, 0, 0, 2'b00, 0, 0, 0);
      for (int k = 1; k <= 9; k++) begin
         step(0, 1, 0, 2'b00, 0, 0, 0);
         step(0, 1, 0, 2'b10, 1, 0, 0);
         step(0, 0, 0, 2'b00, 0, 1, 0);
         check($sformatf("fill%0d", k), {(k == 9) ? 6'b000101 : 6'b000000, 4'(9 - k)});
      end
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 2'b00, 0, 0, 0);
         check($sformatf("full_block%0d", i), {6'b000101, 4'd0});
      end
      step(0, 1, 0, 2'b00, 0, 0, 1);
      check("full_exit", {6'b000000, 4'd1});
      step(0, 1, 0, 2'b00, 0, 0, 0);
      check("full_release_grant", {6'b100100, 4'd1});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/parking_gate_arbiter.md
PARKING_GATE_ARBITER -- requirements
Module: parking_gate_arbiter

Interface
REQ-001 Parameter CAPACITY, default 9: number of parking slots, legal range 1..15.
REQ-002 Parameter PASS_A, default 2'b10: entry code for lane A.
REQ-003 Parameter PASS_B, default 2'b01: entry code for lane B.
REQ-004 Parameter OPEN_CYCLES, default 8: gate-open window in clocks, minimum 1.
REQ-005 Parameter MAX_TRIES, default 3: wrong codes allowed before lockout.
REQ-006 Parameter LOCK_CYCLES, default 16: lockout duration in clocks, minimum 1.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 req_a  input  1  front sensor, lane A; car waiting.
REQ-010 req_b  input  1  front sensor, lane B; car waiting.
REQ-011 password  input  2  shared keypad code.
REQ-012 pass_vld  input  1  one-cycle strobe; password valid this cycle.
REQ-013 back_sensor  input  1  car has passed the shared gate.
REQ-014 exit_sensor  input  1  one-cycle pulse; car left the lot.
REQ-015 grant_a / grant_b  output  1 each  lane currently owns the gate.
REQ-016 green_LED  output  1  gate open.
REQ-017 red_LED  output  1  gate closed, code expected or lockout.
REQ-018 display_screen  output  4  free slots, CAPACITY - occupancy.
REQ-019 full  output  1  occupancy == CAPACITY.
REQ-020 lockout  output  1  lockout in progress.

Function
REQ-021 The FSM SHALL have states IDLE, CHECK, OPEN and LOCK; all outputs are registered and reflect state after the clock edge.
REQ-022 IDLE: grants 0, LEDs 0; with full==0 and a request present, the block SHALL grant one lane and enter CHECK the next edge.
REQ-023 Round-robin: if both lanes request, the lane named by the rr pointer SHALL win; a single requester wins regardless of pointer.
REQ-024 rr pointer SHALL toggle to the other lane on every exit from OPEN or LOCK; it SHALL NOT change on an abandon from CHECK.
REQ-025 IDLE with full==1: no grant; red_LED SHALL be 1; requests stay pending.
REQ-026 CHECK: red_LED=1 and the grant is held. pass_vld with the granted lane's code SHALL move to OPEN, load the timer with OPEN_CYCLES and clear the try counter.
REQ-027 CHECK: pass_vld with a wrong code SHALL increment tries; when tries reaches MAX_TRIES, the block SHALL enter LOCK with timer=LOCK_CYCLES and tries cleared.
REQ-028 CHECK: if the granted lane's req drops and pass_vld is 0 that cycle, the block SHALL return to IDLE with tries cleared; pass_vld takes priority over the drop.
REQ-029 OPEN: green_LED=1, red_LED=0, grant held, timer decrements each cycle.
REQ-030 OPEN: back_sensor SHALL increment occupancy and go to IDLE; if the timer reaches 0 first, the block SHALL go to IDLE with occupancy unchanged. back_sensor on the expiry cycle counts as an entry.
REQ-031 back_sensor outside OPEN SHALL be ignored.
REQ-032 LOCK: red_LED=1 and lockout=1 with grants 0; after LOCK_CYCLES cycles the block SHALL return to IDLE; pass_vld is ignored.
REQ-033 exit_sensor SHALL decrement occupancy in any state; it is ignored when occupancy==0.
REQ-034 If an increment and a decrement occur in the same cycle, occupancy SHALL be unchanged.
REQ-035 Occupancy SHALL never exceed CAPACITY; an entry is impossible when full because no grant is issued.
REQ-036 display_screen and full SHALL update the cycle after occupancy changes.

Reset
REQ-037 rst=1 SHALL force: state IDLE, occupancy 0, tries 0, timer 0, rr pointer to lane A.
REQ-038 Output reset values: grants 0, green_LED 0, red_LED 0, lockout 0, full 0, display_screen=CAPACITY.
REQ-039 Reset asserted mid-OPEN or mid-LOCK SHALL abort the operation without counting an entry.

Verification
REQ-040 Entry: req_a=1, pass_vld with password=2'b10, back_sensor 3 cycles later -> grant_a, green_LED, then display_screen 9->8.
REQ-041 Lockout: req_b=1, three pass_vld with password=2'b00 -> lockout=1 and red_LED=1 for 16 cycles, then IDLE; next contested grant goes to lane A.
REQ-042 Contention: req_a=req_b=1 after reset -> grant_a first; after its entry, grant_b.
REQ-043 Full: fill 9 cars -> full=1, display_screen=0, no grant; one exit_sensor pulse -> full=0, pending request granted.
REQ-044 Edge cases: OPEN with no back_sensor for 8 cycles -> IDLE, count unchanged; back_sensor coincident with exit_sensor -> count unchanged; exit_sensor at 0 -> display_screen stays 9.
